rom_burst_arbiter: RTL and testbench
====================================

Name: rom_burst_arbiter

Overview:
Shares one combinational parametrizable ROM (addr in, dout out, no clock) between N_REQ requesters. Each requester asks for a burst of consecutive words (start address, length). Arbitration is round-robin. The block drives the ROM address, registers each ROM word into an output stage with a valid/ready handshake, and tags every beat with the owner's index. It sits between the ROM instance and the table-lookup clients.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR, 2, ROM address width
DOUT, 14, ROM word width
MEM, 4, number of ROM words (MEM <= 2**ADDR, need not be a power of two)
LEN_W, 3, burst length field width (ADDR+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester burst request, level, held until its gnt bit pulses
req_addr  in  N_REQ*ADDR  start address, requester i at [i*ADDR +: ADDR]
req_len  in  N_REQ*LEN_W  beat count, requester i at [i*LEN_W +: LEN_W]
gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted
err  out  1  one-cycle pulse with gnt when start address >= MEM
busy  out  1  high while in BURST
rom_addr  out  ADDR  to ROM addr
rom_dout  in  DOUT  from ROM dout
rd_data  out  DOUT  registered ROM word
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts the beat when rd_valid && rd_ready
rd_id  out  $clog2(N_REQ)  owner of the current beat
rd_last  out  1  final beat of a burst

Behaviour:
- Reset, asynchronous, while rst_n=0: state=IDLE, rr_ptr=0. All of gnt, err, busy, rd_valid and rd_last are 0. rom_addr, rd_data and rd_id are 0.
- States: IDLE, BURST.
- IDLE, on a clock edge with any req bit high:
  - Winner = first asserted req found scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Register gnt[winner]=1 for exactly one cycle; latch addr_q=req_addr[winner], rem_q=req_len[winner], owner_q=winner.
  - rr_ptr <= (winner+1) mod N_REQ.
  - If req_len=0: gnt pulses, no beats, stay IDLE.
  - If req_addr >= MEM: gnt and err pulse together, no beats, stay IDLE.
  - Otherwise go to BURST.
- BURST:
  - rom_addr = addr_q.
  - Load the output stage when (!rd_valid || rd_ready): rd_data <= rom_dout, rd_id <= owner_q, rd_valid <= 1, rd_last <= (rem_q==1).
  - On each load: rem_q--, and addr_q <= (addr_q==MEM-1) ? 0 : addr_q+1 (wraps at MEM, not at 2**ADDR).
  - The load with rem_q==1 returns the block to IDLE.
  - Stall (rd_valid && !rd_ready): hold rd_data, rd_id, rd_last, addr_q and rem_q unchanged.
- Output stage outside loads: a beat accepted with no new load clears rd_valid and rd_last. In IDLE, rom_addr holds its last value.
- Latency: req seen at edge T → gnt high during cycle T+1 → first beat valid T+2. With rd_ready=1, one beat per cycle. Next arbitration happens on the edge after the last load, so back-to-back bursts have no gap if the new burst is granted while the old last beat drains.
- Requests are sampled only in IDLE. A req change during BURST has no effect. A req dropped before gnt is simply not considered.
- busy = (state==BURST).
- Reset mid-burst: burst abandoned, no rd_last is produced, and all state returns to reset values immediately.
- req_len > MEM is legal: addresses wrap and words repeat.

Decomposition:
- Package rom_arb_pkg: state enum (IDLE, BURST), function clog2-safe ID width, and rr_pick(req, ptr) returning the winner index.
- Sub-module rr_arbiter: combinational round-robin picker, inputs req and rr_ptr, outputs winner index and any_req.
- The top level holds the FSM, address/length counters and output register.

Test Plan:
- Reset, then req=0001, addr0=1, len0=3, rd_ready=1, bench ROM mem[i]=i+1 → gnt=0001 at T+1; beats 2,3,4 on T+2..T+4; rd_id=0; rd_last only on the 4; busy low after T+4.
- Wrap: addr=3, len=3 → beats 4,1,2 (addresses 3,0,1). With MEM=3, ADDR=2, addr=2, len=2 → addresses 2,0.
- Round-robin: req=1111 held, each len=1 → grant order 0,1,2,3,0. rd_id follows the same order.
- Backpressure: len=3, rd_ready low for 2 cycles after the first beat → rd_data stays 2 for 3 cycles, then 3,4. No beat lost or duplicated.
- Edge requests: len=0 → gnt pulse, no rd_valid. addr=3 with MEM=3 → gnt+err pulse, no beats, stay IDLE.
- rst_n low during the second beat of a len=4 burst → rd_valid=0, gnt=0 and busy=0 immediately. After release, a req=0010 wins (rr_ptr=0 scan).

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter: FSM state, ID width
// and the round-robin winner search.
package rom_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int MAX_REQ = 8;

  // Never returns 0 so a single-requester build still has a 1-bit ID.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Descending scan so the nearest asserted bit at or after ptr wins last.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    int idx;
    rr_pick = 0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (req[idx[2:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req scanning up from rr_ptr.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDW = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [IDW-1:0]   winner,
  output logic             any_req
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req);

  always_comb begin
    winner  = IDW'(rr_pick(req_ext, N_REQ, int'(rr_ptr)));
    any_req = |req;
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst reader in front of a combinational ROM; each ROM word is
// registered into a valid/ready output stage tagged with its owner.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR  = 2,
  parameter int DOUT  = 14,
  parameter int MEM   = 4,
  parameter int LEN_W = 3,
  localparam int IDW  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ADDR-1:0]  req_addr,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic                   err,
  output logic                   busy,
  output logic [ADDR-1:0]        rom_addr,
  input  logic [DOUT-1:0]        rom_dout,
  output logic [DOUT-1:0]        rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [IDW-1:0]         rd_id,
  output logic                   rd_last
);

  localparam logic [ADDR:0]   MEM_C    = (ADDR+1)'(MEM);
  localparam logic [ADDR-1:0] MEM_LAST = ADDR'(MEM - 1);

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, rd_id_q, rd_id_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               err_q, err_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [ADDR-1:0]    addr_q, addr_d, last_addr_q, last_addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [DOUT-1:0]    rd_data_q, rd_data_d;

  logic [IDW-1:0]     winner;
  logic               any_req, load;
  logic [ADDR-1:0]    win_addr;
  logic [LEN_W-1:0]   win_len;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign win_addr = req_addr[winner*ADDR +: ADDR];
  assign win_len  = req_len[winner*LEN_W +: LEN_W];
  assign load     = (state_q == BURST) && (!rd_valid_q || rd_ready);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    last_addr_d = last_addr_q;
    gnt_d       = '0;
    err_d       = 1'b0;
    rd_data_d   = rd_data_q;
    rd_id_d     = rd_id_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;

    // Drain; a load below in the same cycle takes precedence.
    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d[winner] = 1'b1;
          owner_d       = winner;
          addr_d        = win_addr;
          rem_d         = win_len;
          rr_ptr_d      = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
          if ({1'b0, win_addr} >= MEM_C) err_d = 1'b1;
          else if (win_len != '0)        state_d = BURST;
        end
      end
      BURST: begin
        last_addr_d = addr_q;
        if (load) begin
          rd_data_d  = rom_dout;
          rd_id_d    = owner_q;
          rd_valid_d = 1'b1;
          rd_last_d  = (rem_q == LEN_W'(1));
          rem_d      = rem_q - 1'b1;
          addr_d     = (addr_q == MEM_LAST) ? '0 : addr_q + 1'b1;
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      last_addr_q <= '0;
      gnt_q       <= '0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_id_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      last_addr_q <= last_addr_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      rd_id_q     <= rd_id_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  // ROM is combinational, so the live address must lead the load edge.
  assign rom_addr = (state_q == BURST) ? addr_q : last_addr_q;
  assign gnt      = gnt_q;
  assign err      = err_q;
  assign busy     = (state_q == BURST);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench: a MEM=4 instance for the main scenarios and a MEM=3 instance
// for wrap-at-MEM and out-of-range starts; ROM model is mem[i] = i+1.
module tb_rom_burst_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0]  req4, gnt4, req3, gnt3;
  logic [7:0]  req_addr4, req_addr3;
  logic [11:0] req_len4, req_len3;
  logic        err4, busy4, rd_valid4, rdy4, rd_last4;
  logic        err3, busy3, rd_valid3, rdy3, rd_last3;
  logic [1:0]  rom_addr4, rd_id4, rom_addr3, rd_id3;
  logic [13:0] rom_dout4, rd_data4, rom_dout3, rd_data3;

  assign rom_dout4 = {12'd0, rom_addr4} + 14'd1;
  assign rom_dout3 = (rom_addr3 == 2'd3) ? 14'd0 : {12'd0, rom_addr3} + 14'd1;

  rom_burst_arbiter #(.N_REQ(4), .ADDR(2), .DOUT(14), .MEM(4), .LEN_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .req_addr(req_addr4), .req_len(req_len4),
    .gnt(gnt4), .err(err4), .busy(busy4), .rom_addr(rom_addr4), .rom_dout(rom_dout4),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_ready(rdy4), .rd_id(rd_id4), .rd_last(rd_last4));

  rom_burst_arbiter #(.N_REQ(4), .ADDR(2), .DOUT(14), .MEM(3), .LEN_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(req_addr3), .req_len(req_len3),
    .gnt(gnt3), .err(err3), .busy(busy3), .rom_addr(rom_addr3), .rom_dout(rom_dout3),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_ready(rdy3), .rd_id(rd_id3), .rd_last(rd_last3));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req4 = '0; req_addr4 = '0; req_len4 = '0; rdy4 = 1'b1;
    req3 = '0; req_addr3 = '0; req_len3 = '0; rdy3 = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req4 = 4'b0001; req_len4 = 12'd3; rdy4 = 1'b1;
    tick(); tick();
    checks++; if ({gnt4, err4, busy4, rd_valid4, rd_last4} !== 8'd0) begin errors++; $display("FAIL reset_ctrl got %b want 0", {gnt4, err4, busy4, rd_valid4, rd_last4}); end
    checks++; if ({rom_addr4, rd_data4, rd_id4} !== 18'd0) begin errors++; $display("FAIL reset_data got %h want 0", {rom_addr4, rd_data4, rd_id4}); end
    req4 = '0;
  endtask

  task automatic test_basic();
    logic [13:0] exp_d [3] = '{14'd2, 14'd3, 14'd4};
    do_reset();
    req4 = 4'b0001; req_addr4[1:0] = 2'd1; req_len4[2:0] = 3'd3;
    tick();
    checks++; if (gnt4 !== 4'b0001 || busy4 !== 1'b1) begin errors++; $display("FAIL basic_gnt got gnt=%b busy=%b want 0001 1", gnt4, busy4); end
    req4 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rd_valid4 !== 1'b1 || rd_data4 !== exp_d[i] || rd_id4 !== 2'd0 || rd_last4 !== (i == 2) || busy4 !== (i != 2)) begin
        errors++; $display("FAIL basic_beat%0d got v=%b d=%0d id=%0d last=%b busy=%b want d=%0d", i, rd_valid4, rd_data4, rd_id4, rd_last4, busy4, exp_d[i]);
      end
    end
    tick();
    checks++; if (rd_valid4 !== 1'b0 || rd_last4 !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%b last=%b want 0 0", rd_valid4, rd_last4); end
  endtask

  task automatic test_wrap();
    logic [13:0] exp4 [3] = '{14'd4, 14'd1, 14'd2};
    logic [13:0] exp3 [2] = '{14'd3, 14'd1};
    do_reset();
    req4 = 4'b0001; req_addr4[1:0] = 2'd3; req_len4[2:0] = 3'd3;
    req3 = 4'b0001; req_addr3[1:0] = 2'd2; req_len3[2:0] = 3'd2;
    tick();
    req4 = '0; req3 = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rd_valid4 !== 1'b1 || rd_data4 !== exp4[i]) begin errors++; $display("FAIL wrap4_beat%0d got v=%b d=%0d want %0d", i, rd_valid4, rd_data4, exp4[i]); end
      if (i < 2) begin
        checks++; if (rd_valid3 !== 1'b1 || rd_data3 !== exp3[i] || rd_last3 !== (i == 1)) begin errors++; $display("FAIL wrap3_beat%0d got v=%b d=%0d last=%b want %0d", i, rd_valid3, rd_data3, rd_last3, exp3[i]); end
      end
    end
  endtask

  task automatic test_round_robin();
    int gq [$];
    int iq [$];
    int exp_rr [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req4 = 4'hF; req_addr4 = '0; req_len4 = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int c = 0; c < 11; c++) begin
      tick();
      for (int b = 0; b < 4; b++) if (gnt4[b]) gq.push_back(b);
      if (rd_valid4) iq.push_back(int'(rd_id4));
    end
    req4 = '0;
    checks++; if (gq.size() < 5 || iq.size() < 5) begin errors++; $display("FAIL rr_count got %0d grants %0d beats want >=5", gq.size(), iq.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (gq[i] != exp_rr[i]) begin errors++; $display("FAIL rr_gnt%0d got %0d want %0d", i, gq[i], exp_rr[i]); end
        checks++; if (iq[i] != exp_rr[i]) begin errors++; $display("FAIL rr_id%0d got %0d want %0d", i, iq[i], exp_rr[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] exp_d [5] = '{14'd2, 14'd2, 14'd2, 14'd3, 14'd4};
    do_reset();
    req4 = 4'b0001; req_addr4[1:0] = 2'd1; req_len4[2:0] = 3'd3;
    tick();
    req4 = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rd_valid4 !== 1'b1 || rd_data4 !== exp_d[i] || rd_last4 !== (i == 4)) begin errors++; $display("FAIL bp_beat%0d got v=%b d=%0d last=%b want %0d", i, rd_valid4, rd_data4, rd_last4, exp_d[i]); end
      rdy4 = (i >= 2);
    end
    tick();
    checks++; if (rd_valid4 !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b want 0", rd_valid4); end
  endtask

  task automatic test_edge();
    do_reset();
    req4 = 4'b0001; req_addr4[1:0] = 2'd0; req_len4[2:0] = 3'd0;
    req3 = 4'b0001; req_addr3[1:0] = 2'd3; req_len3[2:0] = 3'd2;
    tick();
    checks++; if (gnt4 !== 4'b0001 || err4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL len0_gnt got gnt=%b err=%b busy=%b want 0001 0 0", gnt4, err4, busy4); end
    checks++; if (gnt3 !== 4'b0001 || err3 !== 1'b1 || busy3 !== 1'b0) begin errors++; $display("FAIL oob_gnt got gnt=%b err=%b busy=%b want 0001 1 0", gnt3, err3, busy3); end
    req4 = '0; req3 = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (rd_valid4 | rd_valid3 | busy4 | busy3 | err3 | (|gnt4) | (|gnt3)) begin errors++; $display("FAIL edge_quiet%0d got v4=%b v3=%b b4=%b b3=%b e3=%b want 0", i, rd_valid4, rd_valid3, busy4, busy3, err3); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req4 = 4'b0001; req_addr4[1:0] = 2'd0; req_len4[2:0] = 3'd4;
    tick();
    req4 = '0;
    tick(); tick();
    checks++; if (rd_valid4 !== 1'b1 || rd_data4 !== 14'd2 || busy4 !== 1'b1) begin errors++; $display("FAIL mid_beat2 got v=%b d=%0d busy=%b want 1 2 1", rd_valid4, rd_data4, busy4); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_valid4 | (|gnt4) | busy4 | rd_last4) begin errors++; $display("FAIL mid_reset got v=%b gnt=%b busy=%b last=%b want 0", rd_valid4, gnt4, busy4, rd_last4); end
    tick();
    rst_n = 1'b1;
    req4 = 4'b0010; req_addr4 = '0; req_len4 = '0;
    req_addr4[3:2] = 2'd2; req_len4[5:3] = 3'd1;
    tick();
    checks++; if (gnt4 !== 4'b0010) begin errors++; $display("FAIL post_reset_gnt got %b want 0010", gnt4); end
    req4 = '0;
    tick();
    checks++; if (rd_valid4 !== 1'b1 || rd_data4 !== 14'd3 || rd_id4 !== 2'd1 || rd_last4 !== 1'b1) begin errors++; $display("FAIL post_reset_beat got v=%b d=%0d id=%0d last=%b want 1 3 1 1", rd_valid4, rd_data4, rd_id4, rd_last4); end
  endtask

  initial begin
    rst_n = 1'b0;
    req4 = '0; req_addr4 = '0; req_len4 = '0; rdy4 = 1'b1;
    req3 = '0; req_addr3 = '0; req_len3 = '0; rdy3 = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_edge();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
